// File: rtl/rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_buffer_pkg
// Description : Shared types and constants for the receive byte buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_buffer_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int BYTE_W        = 8;
    localparam int ERR_W         = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_buffer_if
// Description : Receiver handshake and FIFO read/status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_buffer_if
    import rx_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) ();

    logic                     rx_ready;
    logic                     rx_error;
    logic [BYTE_W-1:0]        rx_po;
    logic                     rx_ack;
    logic                     rd_en;
    logic [BYTE_W-1:0]        rd_data;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [ERR_W-1:0]         err_cnt;

    modport slave (
        input  rx_ready, rx_error, rx_po, rd_en,
        output rx_ack, rd_data, empty, full, count, overflow, err_cnt
    );

    modport master (
        output rx_ready, rx_error, rx_po, rd_en,
        input  rx_ack, rd_data, empty, full, count, overflow, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Single-bit multi-flop synchronizer with synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rx_buffer
// Description : Four-phase receiver capture into a first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_buffer
    import rx_buffer_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    rx_buffer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic              rdy_s;
    logic              err_s;
    state_t            state;
    state_t            state_next;
    logic              ack_q;
    logic              capture;
    logic              pop;
    logic              wr_ok;
    logic              do_write;
    logic              is_empty;
    logic              is_full;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              ovf;
    logic [ERR_W-1:0]  err_count;
    logic [BYTE_W-1:0] mem [DEPTH];

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rdy (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx_ready),
        .q   (rdy_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_err (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx_error),
        .q   (err_s)
    );

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));
    assign pop      = bus.rd_en && !is_empty;
    // A full FIFO still accepts a byte when a pop frees a slot on the same edge
    assign wr_ok    = !is_full || pop;
    assign do_write = capture && !err_s && wr_ok;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (rdy_s) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!rdy_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ack_q <= 1'b0;
        end else begin
            state <= state_next;
            ack_q <= (state_next == ACK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            err_count <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_write, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (capture && !err_s && !wr_ok) begin
                ovf <= 1'b1;
            end
            if (capture && err_s && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    // Storage has no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            mem[wr_ptr] <= bus.rx_po;
        end
    end

    assign bus.rx_ack   = ack_q;
    assign bus.rd_data  = mem[rd_ptr];
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.count    = cnt;
    assign bus.overflow = ovf;
    assign bus.err_cnt  = err_count;

endmodule
`default_nettype wire

// File: tb/tb_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_buffer
// Description : Directed self-checking bench for rx_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_buffer;
    import rx_buffer_pkg::*;

    localparam int DEPTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int WAIT_MAX    = 20;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   lat;

    rx_buffer_if #(.DEPTH(DEPTH)) bus ();

    rx_buffer #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the number of edges until rx_ack reaches lvl, or -1 on timeout
    task automatic wait_ack(input logic lvl, output int n);
        n = 0;
        while (bus.rx_ack !== lvl && n < WAIT_MAX) begin
            tick(1);
            n++;
        end
        if (bus.rx_ack !== lvl) begin
            chk("ack_timeout", 32'(bus.rx_ack), 32'(lvl));
            n = -1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e, output int l);
        int n;
        bus.rx_po    = d;
        bus.rx_error = e;
        bus.rx_ready = 1'b1;
        wait_ack(1'b1, l);
        bus.rx_ready = 1'b0;
        wait_ack(1'b0, n);
        bus.rx_error = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.rx_ready = 1'b0;
        bus.rx_error = 1'b0;
        bus.rx_po    = '0;
        bus.rd_en    = 1'b0;
        tick(1);
        do_reset();

        chk("rst_empty",    32'(bus.empty),    32'd1);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_count",    32'(bus.count),    32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_err_cnt",  32'(bus.err_cnt),  32'd0);
        chk("rst_ack",      32'(bus.rx_ack),   32'd0);

        // Single byte
        send_byte(8'hA9, 1'b0, lat);
        chk("single_latency", 32'(lat),          32'(LAT));
        chk("single_data",    32'(bus.rd_data),  32'h0A9);
        chk("single_count",   32'(bus.count),    32'd1);
        chk("single_empty",   32'(bus.empty),    32'd0);
        pop_one();
        chk("single_popped",  32'(bus.empty),    32'd1);

        // Error byte
        send_byte(8'h10, 1'b1, lat);
        chk("err_latency", 32'(lat),         32'(LAT));
        chk("err_count",   32'(bus.count),   32'd0);
        chk("err_err_cnt", 32'(bus.err_cnt), 32'd1);
        chk("err_ack_low", 32'(bus.rx_ack),  32'd0);

        // Fill plus one overflow
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(i), 1'b0, lat);
        end
        chk("fill_full",     32'(bus.full),     32'd1);
        chk("fill_count",    32'(bus.count),    32'd8);
        chk("fill_overflow", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill_pop%0d", i), 32'(bus.rd_data), 32'(i));
            pop_one();
        end
        chk("fill_drained", 32'(bus.empty), 32'd1);
        pop_one();
        chk("empty_pop_count", 32'(bus.count), 32'd0);
        chk("empty_pop_empty", 32'(bus.empty), 32'd1);

        // Full FIFO with a pop on the capture edge
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h20 + 8'(i), 1'b0, lat);
        end
        chk("wrap_full", 32'(bus.full),    32'd1);
        chk("wrap_head", 32'(bus.rd_data), 32'h020);
        bus.rx_po    = 8'h28;
        bus.rx_ready = 1'b1;
        tick(LAT - 1);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        chk("wrap_ack",      32'(bus.rx_ack),   32'd1);
        chk("wrap_count",    32'(bus.count),    32'd8);
        chk("wrap_overflow", 32'(bus.overflow), 32'd0);
        bus.rx_ready = 1'b0;
        wait_ack(1'b0, lat);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wrap_pop%0d", i), 32'(bus.rd_data), 32'h21 + 32'(i));
            pop_one();
        end
        chk("wrap_drained", 32'(bus.empty), 32'd1);

        // Reset while the handshake is in ACK
        bus.rx_po    = 8'h5C;
        bus.rx_ready = 1'b1;
        wait_ack(1'b1, lat);
        chk("rack_count_before", 32'(bus.count), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rack_ack",   32'(bus.rx_ack), 32'd0);
        chk("rack_count", 32'(bus.count),  32'd0);
        chk("rack_empty", 32'(bus.empty),  32'd1);
        wait_ack(1'b1, lat);
        chk("rack_relatency", 32'(lat), 32'(LAT));
        bus.rx_ready = 1'b0;
        wait_ack(1'b0, lat);
        tick(4);
        chk("rack_recount", 32'(bus.count),   32'd1);
        chk("rack_data",    32'(bus.rd_data), 32'h05C);

        // Error counter saturation
        for (int i = 0; i < 255; i++) begin
            send_byte(8'h77, 1'b1, lat);
        end
        chk("sat_255", 32'(bus.err_cnt), 32'd255);
        send_byte(8'h77, 1'b1, lat);
        chk("sat_hold",  32'(bus.err_cnt), 32'd255);
        chk("sat_count", 32'(bus.count),   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_buffer.md
RX_BUFFER -- requirements
Module: rx_buffer

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries, power of two, 2..16.
REQ-002 Parameter SYNC_STAGES, default 2: flops on each asynchronous input.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_ready  input  1  receiver byte-valid flag, asynchronous to clk, held until rx_ack seen.
REQ-006 rx_error  input  1  receiver frame/parity error flag, valid while rx_ready high.
REQ-007 rx_po  input  8  received byte, stable while rx_ready high.
REQ-008 rx_ack  output  1  registered acknowledge to receiver.
REQ-009 rd_en  input  1  pop request.
REQ-010 rd_data  output  8  head entry, first-word-fall-through.
REQ-011 empty / full  output  1 each  FIFO status.
REQ-012 count  output  $clog2(DEPTH)+1  occupancy.
REQ-013 overflow  output  1  sticky: byte dropped because FIFO full.
REQ-014 err_cnt  output  8  saturating count of bytes received with rx_error.

Function
REQ-015 rx_ready and rx_error SHALL each pass through SYNC_STAGES flops before use (rdy_s, err_s); rx_po SHALL be sampled directly, only when rdy_s=1.
REQ-016 Capture FSM SHALL have states IDLE, ACK.
REQ-017 IDLE, rdy_s=1: perform capture action (REQ-018..020) on that edge, go ACK; otherwise stay IDLE.
REQ-018 Capture with err_s=0 and write permitted: write rx_po at wr_ptr, wr_ptr wraps DEPTH-1 -> 0.
REQ-019 Capture with err_s=1: no write; err_cnt += 1, holding at 255.
REQ-020 Capture with err_s=0 and write not permitted: no write; overflow set to 1 until reset.
REQ-021 Write permitted when !full, or when full and an accepted pop occurs in the same cycle.
REQ-022 ACK: rx_ack=1; stay until rdy_s=0, then go IDLE with rx_ack=0 (four-phase handshake; exactly one capture per rx_ready assertion).
REQ-023 rx_ack SHALL be a flop output, equal to 1 exactly while state=ACK.
REQ-024 Latency: rx_ready rising to entry visible on rd_data (when empty) = SYNC_STAGES+1 clk edges.
REQ-025 Pop accepted when rd_en=1 and !empty; rd_ptr advances with wrap; rd_en while empty ignored, no state change.
REQ-026 rd_data = mem[rd_ptr] combinationally; value undefined-but-stable when empty.
REQ-027 Simultaneous accepted write and pop: count unchanged, both pointers advance.
REQ-028 empty = (count==0); full = (count==DEPTH); both derived from registered count.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, rx_ack=0, pointers=0, count=0, empty=1, full=0, overflow=0, err_cnt=0, sync flops=0; memory contents not cleared.
REQ-030 Reset mid-handshake SHALL drop rx_ack; a still-high rx_ready after reset SHALL be re-captured once as a new byte.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (IDLE=0, ACK=1), default DEPTH and byte width 8.
REQ-032 Synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, 1-bit), instantiated twice.
REQ-033 Memory SHALL be a register array without reset, inferable as distributed RAM.

Verification
REQ-034 Single byte: rx_po=8'hA9, rx_ready high until rx_ack -> rx_ack rises SYNC_STAGES+1 edges later, rd_data=8'hA9, count=1, empty=0.
REQ-035 Error byte: rx_error=1 with rx_po=8'h10 -> count stays 0, err_cnt=1, rx_ack still completes handshake.
REQ-036 Fill: write 8'h00..8'h08 (9 bytes), no reads -> full=1, count=8, overflow=1, pops return 8'h00..8'h07 in order.
REQ-037 Wrap plus concurrent: FIFO full, rd_en held high during 9th capture -> byte stored, overflow=0, count stays 8, later pops show correct order across pointer wrap.
REQ-038 Reset during ACK: rst pulsed while rx_ack=1 and rx_ready=1 -> rx_ack=0 next edge, all status at reset values, same byte captured again once.
REQ-039 err_cnt saturation: 256 error bytes -> err_cnt=255 and holds.
